// File: rtl/event_token_ring.sv
// rtl/event_token_ring.sv - N-party round-robin token ring with start delay, round counting and stall detection
module event_token_ring #(
  parameter int N_PARTIES   = 2,
  parameter int ROUNDS      = 10,
  parameter int START_DELAY = 100,
  parameter int STALL_MAX   = 0,
  parameter int CNT_W       = 16,
  localparam int PW = (N_PARTIES > 2) ? $clog2(N_PARTIES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [N_PARTIES-1:0] ev_ready,
  output logic [N_PARTIES-1:0] ev_valid,
  output logic [PW-1:0]        cur_party,
  output logic [CNT_W-1:0]     round_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  if (N_PARTIES < 2) begin : g_bad_parties
    $error("event_token_ring: N_PARTIES must be >= 2");
  end
  if (ROUNDS < 1 || (longint'(ROUNDS) >> CNT_W) != 0) begin : g_bad_rounds
    $error("event_token_ring: ROUNDS must be >= 1 and fit in CNT_W bits");
  end
  if (START_DELAY < 0 || (longint'(START_DELAY) >> CNT_W) != 0) begin : g_bad_delay
    $error("event_token_ring: START_DELAY must fit in CNT_W bits");
  end
  if (STALL_MAX < 0 || (longint'(STALL_MAX) >> CNT_W) != 0) begin : g_bad_stall
    $error("event_token_ring: STALL_MAX must fit in CNT_W bits");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_FIRE,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    party_q, party_d;
  logic [CNT_W-1:0] round_q, round_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic             hs;
  logic             last_party;
  logic [CNT_W-1:0] round_inc;

  assign hs         = (state_q == S_FIRE) && ev_ready[party_q];
  assign last_party = (party_q == PW'(N_PARTIES - 1));
  assign round_inc  = (round_q == '1) ? round_q : round_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      party_q <= '0;
      round_q <= '0;
      dly_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      party_q <= party_d;
      round_q <= round_d;
      dly_q   <= dly_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    party_d = party_q;
    round_d = round_q;
    dly_d   = dly_q;
    stall_d = stall_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          stall_d = '0;
          if (START_DELAY > 0) begin
            state_d = S_DELAY;
            dly_d   = CNT_W'(START_DELAY - 1);
          end else begin
            state_d = S_FIRE;
          end
        end
      end
      S_DELAY: begin
        if (dly_q == '0) begin
          state_d = S_FIRE;
          stall_d = '0;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      S_FIRE: begin
        // A handshake wins over a stall timeout landing on the same edge.
        if (hs) begin
          stall_d = '0;
          if (last_party) begin
            party_d = '0;
            round_d = round_inc;
            if (round_inc == CNT_W'(ROUNDS)) state_d = S_DONE;
          end else begin
            party_d = party_q + 1'b1;
          end
        end else if (STALL_MAX > 0) begin
          if (stall_q == CNT_W'(STALL_MAX - 1)) state_d = S_ERR;
          else stall_d = stall_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ev_valid = '0;
    if (state_q == S_FIRE) ev_valid[party_q] = 1'b1;
  end

  assign cur_party = party_q;
  assign round_cnt = round_q;
  assign busy      = (state_q == S_DELAY) || (state_q == S_FIRE);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);

endmodule
